// File: rtl/bin_to_st_sng.sv
// Stochastic number generator: turns an 8-bit unsigned value into a 256-bit
// unipolar stream word, one bit per clock, using a maximal-length LFSR as comparator source.
module bin_to_st_sng #(
  parameter int unsigned         WIDTH = 8,
  parameter logic [WIDTH-1:0]    SEED  = 8'h01
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         bin_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [(1<<WIDTH)-1:0]    st_out,
  output logic                     busy
);

  localparam int unsigned      LEN      = 1 << WIDTH;
  // The LFSR period is LEN-1, so the last generated bit is LEN-2; bit LEN-1 stays 0.
  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(LEN - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q,   bin_d;
  logic [WIDTH-1:0] lfsr_q,  lfsr_d;
  logic [WIDTH-1:0] idx_q,   idx_d;
  logic [LEN-1:0]   st_q,    st_d;

  logic [WIDTH-1:0] lfsr_dec;
  logic [WIDTH-1:0] lfsr_next;
  logic             stream_bit;

  // lfsr-1 walks 0..LEN-2 exactly once, so bin > lfsr-1 yields exactly min(bin, LEN-1) ones.
  assign lfsr_dec   = lfsr_q - WIDTH'(1);
  assign lfsr_next  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign stream_bit = (bin_q > lfsr_dec);

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    st_d    = st_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          bin_d   = bin_in;
          lfsr_d  = SEED;
          idx_d   = '0;
          st_d    = '0;
          state_d = S_GEN;
        end
      end

      S_GEN: begin
        st_d[idx_q] = stream_bit;
        lfsr_d      = lfsr_next;
        idx_d       = idx_q + WIDTH'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      lfsr_q  <= SEED;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
    end
  end

  // The stream word is a plain register, not a memory, and reset clears any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign st_out    = st_q;
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bin_to_st_sng.sv
// Directed self-checking bench for bin_to_st_sng: latency, boundary words,
// full value sweep, backpressure, ignored input during GEN, and mid-conversion reset.
module tb_bin_to_st_sng;

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [7:0]   bin_in    = 8'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] st_out;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bin_to_st_sng #(.WIDTH(8), .SEED(8'h01)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .st_out    (st_out),
    .busy      (busy)
  );

  // Reference word: bit i = (b > s_i - 1) with s_i the taps-7/5/4/3 LFSR sequence from 8'h01.
  function automatic logic [255:0] model_word(input logic [7:0] b);
    logic [255:0] w;
    logic [7:0]   l;
    w = '0;
    l = 8'h01;
    for (int i = 0; i < 255; i++) begin
      w[i] = (b > 8'(l - 8'd1));
      l    = {l[6:0], ^(l & 8'hB8)};
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present b, wait for out_valid (bounded); lat = edges from accept to out_valid.
  task automatic run_conv(input logic [7:0] b, output logic [255:0] w, output int lat);
    @(negedge clk);
    bin_in   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("accept_in_ready_low", 256'(in_ready), 256'(0));
    @(negedge clk);
    in_valid = 1'b0;
    bin_in   = ~b;
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      if (!out_valid) lat++;
    end
    w = st_out;
  endtask

  // With out_ready high, the edge after out_valid is the transfer.
  task automatic handshake_idle();
    @(posedge clk);
    #1;
    check("handshake_out_valid", 256'(out_valid), 256'(0));
    check("handshake_in_ready",  256'(in_ready),  256'(1));
  endtask

  initial begin
    logic [255:0] w;
    logic [255:0] ref37;
    int           lat;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_st_out",    st_out,            256'(0));
    check("rst_flags",     256'({out_valid, in_ready, busy}), 256'(3'b010));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: bin=0, latency and single-cycle out_valid
    out_ready = 1'b1;
    run_conv(8'd0, w, lat);
    check("t1_latency", 256'(lat), 256'(255));
    check("t1_st_zero", w, 256'(0));
    check("t1_busy_hold", 256'(busy), 256'(1));
    handshake_idle();

    // 2: bin=1 and bin=255
    run_conv(8'd1, w, lat);
    check("t2_bit0", 256'(w[0]), 256'(1));
    check("t2_bit1", 256'(w[1]), 256'(0));
    check("t2_pop1", 256'($countones(w)), 256'(1));
    handshake_idle();
    run_conv(8'd255, w, lat);
    check("t2_full", w, {1'b0, {255{1'b1}}});
    handshake_idle();

    // 3: back-to-back sweep of every value
    for (int b = 0; b < 256; b++) begin
      run_conv(8'(b), w, lat);
      check("t3_latency", 256'(lat), 256'(255));
      check("t3_popcount", 256'($countones(w[254:0])), 256'((b < 255) ? b : 255));
      check("t3_word", w, model_word(8'(b)));
      if (b == 37) ref37 = w;
      handshake_idle();
    end

    // 4: backpressure on bin=128, with in_valid pushed during HOLD
    out_ready = 1'b0;
    run_conv(8'd128, w, lat);
    check("t4_pop128", 256'($countones(w)), 256'(128));
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = 8'd9;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("t4_hold_word",  st_out, w);
      check("t4_hold_flags", 256'({out_valid, in_ready, busy}), 256'(3'b101));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_release_flags", 256'({out_valid, in_ready, busy}), 256'(3'b010));
    check("t4_word_kept",     st_out, w);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("t4_still_idle", 256'({out_valid, in_ready, busy}), 256'(3'b010));
    out_ready = 1'b1;

    // 5: in_valid toggling with bin_in=7 during GEN is ignored
    @(negedge clk);
    bin_in   = 8'd50;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(negedge clk);
      in_valid = lat[0];
      bin_in   = 8'd7;
      @(posedge clk);
      #1;
      if (!out_valid) begin
        lat++;
        check("t5_in_ready_low", 256'(in_ready), 256'(0));
      end
    end
    check("t5_latency", 256'(lat), 256'(255));
    check("t5_word", st_out, model_word(8'd50));
    check("t5_pop50", 256'($countones(st_out)), 256'(50));
    @(negedge clk);
    in_valid = 1'b0;
    handshake_idle();

    // 6: reset at GEN idx=100 aborts immediately
    @(negedge clk);
    bin_in   = 8'd90;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("t6_pre_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    #1;
    check("t6_rst_st_out", st_out, 256'(0));
    check("t6_rst_flags",  256'({out_valid, in_ready, busy}), 256'(3'b010));
    @(negedge clk);
    rst = 1'b0;
    run_conv(8'd200, w, lat);
    check("t6_latency", 256'(lat), 256'(255));
    check("t6_pop200", 256'($countones(w)), 256'(200));
    check("t6_word", w, model_word(8'd200));
    handshake_idle();

    // Determinism: a repeated value reproduces the same word
    run_conv(8'd37, w, lat);
    check("det_repeat37", w, ref37);
    handshake_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
